sisc_ctrl_mc: RTL and testbench



---
 rtl/sisc_ctrl_mc.sv | 146 ++++++++++++++
 tb/tb_sisc_ctrl_mc.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/sisc_ctrl_mc.sv
// Multi-cycle control FSM for the SISC processor: fetch/decode/execute/mem/writeback
// with decode-stage branch resolution, mem-ready stall with timeout, and a hardware halt state.
module sisc_ctrl_mc #(
    parameter int OPW    = 4,
    parameter int MMW    = 4,
    parameter int STATW  = 4,
    parameter int MEM_TO = 15
) (
    input  logic             clk,
    input  logic             rst_f,
    input  logic [OPW-1:0]   opcode,
    input  logic [MMW-1:0]   mm,
    input  logic [STATW-1:0] stat,
    input  logic             mem_rdy,
    output logic             pc_rst,
    output logic             ir_load,
    output logic             pc_write,
    output logic             pc_sel,
    output logic             br_sel,
    output logic [1:0]       alu_op,
    output logic             dm_we,
    output logic             rf_we,
    output logic             wb_sel,
    output logic             illegal,
    output logic             mem_err,
    output logic             halted
);
    typedef enum logic [2:0] {
        START0, START1, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT
    } state_t;

    localparam logic [OPW-1:0] OP_NOOP = OPW'(0);
    localparam logic [OPW-1:0] OP_LOD  = OPW'(1);
    localparam logic [OPW-1:0] OP_STR  = OPW'(2);
    localparam logic [OPW-1:0] OP_SWP  = OPW'(3);
    localparam logic [OPW-1:0] OP_BRA  = OPW'(4);
    localparam logic [OPW-1:0] OP_BRR  = OPW'(5);
    localparam logic [OPW-1:0] OP_BNE  = OPW'(6);
    localparam logic [OPW-1:0] OP_BNR  = OPW'(7);
    localparam logic [OPW-1:0] OP_ALU  = OPW'(8);
    localparam logic [OPW-1:0] OP_HLT  = OPW'(15);

    state_t     state, nxt;
    logic [7:0] cnt;
    logic       cond, is_lod, is_str, is_br, is_rel, taken, known, err_set;
    logic [1:0] alu_sel;

    assign is_lod = (opcode == OP_LOD);
    assign is_str = (opcode == OP_STR);
    assign is_br  = (opcode == OP_BRA) || (opcode == OP_BRR) ||
                    (opcode == OP_BNE) || (opcode == OP_BNR);
    assign is_rel = (opcode == OP_BRR) || (opcode == OP_BNR);
    assign cond   = |(stat & mm[STATW-1:0]);
    assign taken  = (((opcode == OP_BRA) || (opcode == OP_BRR)) &&  cond) ||
                    (((opcode == OP_BNE) || (opcode == OP_BNR)) && !cond);
    assign known  = is_br || is_lod || is_str || (opcode == OP_NOOP) ||
                    (opcode == OP_SWP) || (opcode == OP_ALU) || (opcode == OP_HLT);

    // ALU function for EXECUTE; WRITEBACK reuses it since opcode/mm stay stable
    always_comb begin
        alu_sel = 2'b00;
        if (opcode == OP_ALU)       alu_sel = mm[3] ? 2'b01 : 2'b00;
        else if (is_lod || is_str)  alu_sel = 2'b10;
        else if (opcode == OP_SWP)  alu_sel = 2'b11;
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) state <= START0;
        else        state <= nxt;
    end

    // Wait counter lives only in MEM; cleared whenever outside it
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f)             cnt <= '0;
        else if (state != MEM)  cnt <= '0;
        else if (!mem_rdy)      cnt <= cnt + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f)       mem_err <= 1'b0;
        else if (err_set) mem_err <= 1'b1;
    end

    always_comb begin
        nxt      = state;
        pc_rst   = 1'b0;
        ir_load  = 1'b0;
        pc_write = 1'b0;
        pc_sel   = 1'b0;
        br_sel   = 1'b0;
        alu_op   = 2'b00;
        dm_we    = 1'b0;
        rf_we    = 1'b0;
        wb_sel   = 1'b0;
        illegal  = 1'b0;
        halted   = 1'b0;
        err_set  = 1'b0;
        case (state)
            START0: begin pc_rst = 1'b1; nxt = START1; end
            START1: begin pc_rst = 1'b1; nxt = FETCH;  end
            FETCH: begin
                ir_load  = 1'b1;
                pc_write = 1'b1;
                nxt      = DECODE;
            end
            DECODE: begin
                if (is_br) begin
                    pc_write = taken;
                    pc_sel   = taken;
                    br_sel   = taken && is_rel;
                    nxt      = FETCH;
                end else if (opcode == OP_HLT) begin
                    nxt = HALT;
                end else if (!known || opcode == OP_NOOP) begin
                    illegal = !known;
                    nxt     = FETCH;
                end else begin
                    nxt = EXECUTE;
                end
            end
            EXECUTE: begin
                alu_op = alu_sel;
                nxt    = (is_lod || is_str) ? MEM : WRITEBACK;
            end
            MEM: begin
                alu_op = 2'b10;
                dm_we  = is_str;
                if (mem_rdy) begin
                    nxt = is_lod ? WRITEBACK : FETCH;
                end else if (cnt == 8'(MEM_TO - 1)) begin
                    // This is the MEM_TO-th wait cycle; give up
                    err_set = 1'b1;
                    nxt     = HALT;
                end
            end
            WRITEBACK: begin
                alu_op = alu_sel;
                rf_we  = 1'b1;
                wb_sel = is_lod;
                nxt    = FETCH;
            end
            HALT:    halted = 1'b1;
            default: nxt = START0;
        endcase
    end
endmodule

// File: tb/tb_sisc_ctrl_mc.sv
// Directed bench for sisc_ctrl_mc: table of per-cycle vectors plus hand sequences
// for async reset, halt, and mem timeout (second instance with MEM_TO=3).
module tb_sisc_ctrl_mc;
    localparam logic [12:0] E_RST   = 13'h1000;
    localparam logic [12:0] E_FETCH = 13'h0C00;
    localparam logic [12:0] E_IDLE  = 13'h0000;
    localparam logic [12:0] E_XIMM  = 13'h0040;
    localparam logic [12:0] E_WIMM  = 13'h0050;
    localparam logic [12:0] E_WREG  = 13'h0010;
    localparam logic [12:0] E_ADDR  = 13'h0080;
    localparam logic [12:0] E_MSTR  = 13'h00A0;
    localparam logic [12:0] E_WLOD  = 13'h0098;
    localparam logic [12:0] E_XSWP  = 13'h00C0;
    localparam logic [12:0] E_WSWP  = 13'h00D0;
    localparam logic [12:0] E_BABS  = 13'h0600;
    localparam logic [12:0] E_BREL  = 13'h0700;
    localparam logic [12:0] E_ILL   = 13'h0004;
    localparam logic [12:0] E_HALT  = 13'h0001;
    localparam logic [12:0] E_HERR  = 13'h0003;

    typedef struct {
        logic [3:0]  op;
        logic [3:0]  mm;
        logic [3:0]  st;
        logic        rdy;
        logic [12:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_f = 1'b0;
    logic [3:0] opcode = '0, mm = '0, stat = '0;
    logic mem_rdy = 1'b0;

    logic pc_rst, ir_load, pc_write, pc_sel, br_sel, dm_we, rf_we, wb_sel, illegal, mem_err, halted;
    logic [1:0] alu_op;
    logic t_pc_rst, t_ir_load, t_pc_write, t_pc_sel, t_br_sel, t_dm_we, t_rf_we, t_wb_sel;
    logic t_illegal, t_mem_err, t_halted;
    logic [1:0] t_alu_op;
    logic [12:0] obs, t_obs;

    int n_chk = 0;
    int n_err = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    sisc_ctrl_mc #(.OPW(4), .MMW(4), .STATW(4), .MEM_TO(15)) dut (
        .clk(clk), .rst_f(rst_f), .opcode(opcode), .mm(mm), .stat(stat), .mem_rdy(mem_rdy),
        .pc_rst(pc_rst), .ir_load(ir_load), .pc_write(pc_write), .pc_sel(pc_sel),
        .br_sel(br_sel), .alu_op(alu_op), .dm_we(dm_we), .rf_we(rf_we), .wb_sel(wb_sel),
        .illegal(illegal), .mem_err(mem_err), .halted(halted));

    sisc_ctrl_mc #(.OPW(4), .MMW(4), .STATW(4), .MEM_TO(3)) dut_to (
        .clk(clk), .rst_f(rst_f), .opcode(opcode), .mm(mm), .stat(stat), .mem_rdy(mem_rdy),
        .pc_rst(t_pc_rst), .ir_load(t_ir_load), .pc_write(t_pc_write), .pc_sel(t_pc_sel),
        .br_sel(t_br_sel), .alu_op(t_alu_op), .dm_we(t_dm_we), .rf_we(t_rf_we), .wb_sel(t_wb_sel),
        .illegal(t_illegal), .mem_err(t_mem_err), .halted(t_halted));

    assign obs   = {pc_rst, ir_load, pc_write, pc_sel, br_sel, alu_op,
                    dm_we, rf_we, wb_sel, illegal, mem_err, halted};
    assign t_obs = {t_pc_rst, t_ir_load, t_pc_write, t_pc_sel, t_br_sel, t_alu_op,
                    t_dm_we, t_rf_we, t_wb_sel, t_illegal, t_mem_err, t_halted};

    task automatic chk(input string name, input logic [12:0] act, input logic [12:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %0s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic [3:0] op, input logic [3:0] m, input logic [3:0] s,
                       input logic r, input logic [12:0] e);
        vec_t v;
        v.op = op; v.mm = m; v.st = s; v.rdy = r; v.exp = e;
        tbl.push_back(v);
    endtask

    // Drive inputs after negedge, sample mid-cycle; the following posedge advances the FSM
    task automatic step(input logic [3:0] op, input logic [3:0] m, input logic [3:0] s,
                        input logic r, input logic [12:0] e, input string name, input bit to);
        @(negedge clk);
        opcode = op; mm = m; stat = s; mem_rdy = r;
        #1;
        if (to) chk(name, t_obs, e);
        else    chk(name, obs, e);
    endtask

    // Drops rst_f between edges and checks outputs change without a clock, then releases
    task automatic do_reset(input string name);
        @(negedge clk);
        #2;
        rst_f = 1'b0;
        #1;
        chk({name, "_async"}, obs, E_RST);
        chk({name, "_async_t"}, t_obs, E_RST);
        @(negedge clk);
        @(negedge clk);
        rst_f = 1'b1;
        #1;
        chk({name, "_start0"}, obs, E_RST);
        chk({name, "_start0_t"}, t_obs, E_RST);
    endtask

    initial begin
        add(0, 0, 0, 0, E_RST);                                        // START1
        add(8, 8, 0, 0, E_FETCH); add(8, 8, 0, 0, E_IDLE);             // ALU imm
        add(8, 8, 0, 0, E_XIMM);  add(8, 8, 0, 0, E_WIMM);
        add(1, 0, 0, 0, E_FETCH); add(1, 0, 0, 0, E_IDLE);             // LOD, 3 waits
        add(1, 0, 0, 0, E_ADDR);  add(1, 0, 0, 0, E_ADDR);
        add(1, 0, 0, 0, E_ADDR);  add(1, 0, 0, 0, E_ADDR);
        add(1, 0, 0, 1, E_ADDR);  add(1, 0, 0, 0, E_WLOD);
        add(2, 0, 0, 0, E_FETCH); add(2, 0, 0, 0, E_IDLE);             // STR, no wait
        add(2, 0, 0, 0, E_ADDR);  add(2, 0, 0, 1, E_MSTR);
        add(3, 0, 0, 0, E_FETCH); add(3, 0, 0, 0, E_IDLE);             // SWP
        add(3, 0, 0, 0, E_XSWP);  add(3, 0, 0, 0, E_WSWP);
        add(5, 2, 2, 0, E_FETCH); add(5, 2, 2, 0, E_BREL);             // BRR taken
        add(6, 2, 2, 0, E_FETCH); add(6, 2, 2, 0, E_IDLE);             // BNE not taken
        add(4, 2, 0, 0, E_FETCH); add(4, 2, 0, 0, E_IDLE);             // BRA not taken
        add(4, 2, 2, 0, E_FETCH); add(4, 2, 2, 0, E_BABS);             // BRA taken
        add(7, 2, 0, 0, E_FETCH); add(7, 2, 0, 0, E_BREL);             // BNR taken
        add(6, 4, 2, 0, E_FETCH); add(6, 4, 2, 0, E_BABS);             // BNE taken, mask miss
        add(9, 0, 0, 0, E_FETCH); add(9, 0, 0, 0, E_ILL);              // illegal
        add(0, 0, 0, 0, E_FETCH); add(0, 0, 0, 0, E_IDLE);             // NOOP
        add(8, 0, 0, 0, E_FETCH); add(8, 0, 0, 0, E_IDLE);             // ALU reg
        add(8, 0, 0, 0, E_IDLE);  add(8, 0, 0, 0, E_WREG);
        add(2, 0, 0, 0, E_FETCH);

        #1;
        chk("por_reset", obs, E_RST);
        do_reset("rst0");
        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i].op, tbl[i].mm, tbl[i].st, tbl[i].rdy, tbl[i].exp, $sformatf("vec%0d", i), 1'b0);

        // Finish the STR fetched above and abort it mid-wait
        step(2, 0, 0, 0, E_IDLE, "str_dec", 1'b0);
        step(2, 0, 0, 0, E_ADDR, "str_exe", 1'b0);
        step(2, 0, 0, 0, E_MSTR, "str_mem_wait", 1'b0);
        do_reset("midmem");

        step(0, 0, 0, 0, E_RST, "start1_b", 1'b0);
        step(15, 0, 0, 0, E_FETCH, "hlt_fetch", 1'b0);
        step(15, 0, 0, 0, E_IDLE, "hlt_dec", 1'b0);
        for (int i = 0; i < 20; i++)
            step(4'(i), 4'(i), 4'(i), 1'b0, E_HALT, $sformatf("halt%0d", i), 1'b0);

        do_reset("rst_to");
        step(0, 0, 0, 0, E_RST, "t_start1", 1'b1);
        step(2, 0, 0, 0, E_FETCH, "t_fetch0", 1'b1);
        step(2, 0, 0, 0, E_IDLE, "t_dec0", 1'b1);
        step(2, 0, 0, 0, E_ADDR, "t_exe0", 1'b1);
        step(2, 0, 0, 0, E_MSTR, "t_mem0a", 1'b1);
        step(2, 0, 0, 0, E_MSTR, "t_mem0b", 1'b1);
        step(2, 0, 0, 1, E_MSTR, "t_mem0_lastrdy", 1'b1);
        step(2, 0, 0, 0, E_FETCH, "t_fetch_noerr", 1'b1);
        step(2, 0, 0, 0, E_IDLE, "t_dec1", 1'b1);
        step(2, 0, 0, 0, E_ADDR, "t_exe1", 1'b1);
        for (int i = 0; i < 3; i++)
            step(2, 0, 0, 0, E_MSTR, $sformatf("t_mem1_%0d", i), 1'b1);
        for (int i = 0; i < 5; i++)
            step(2, 0, 0, 0, E_HERR, $sformatf("t_herr%0d", i), 1'b1);
        do_reset("rst_clr");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
